// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the stall/flush sequencer: PC source select, controller
// states, and the bundle of latch controls it drives each cycle.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pcsel_t;

    typedef enum logic [2:0] {
        RUN,
        LU_STALL,
        DWAIT,
        REDIR,
        HALT
    } pctl_state_t;

    typedef struct packed {
        logic   pc_en;
        pcsel_t pc_sel;
        logic   ifid_en;
        logic   idex_en;
        logic   exmem_en;
        logic   memwb_en;
        logic   ifid_flush;
        logic   idex_flush;
        logic   exmem_flush;
    } pctl_out_t;

    localparam pctl_out_t PCTL_IDLE = '0;

    function automatic pctl_out_t pctl_all(input logic en);
        pctl_out_t o;
        o          = PCTL_IDLE;
        o.pc_en    = en;
        o.ifid_en  = en;
        o.idex_en  = en;
        o.exmem_en = en;
        o.memwb_en = en;
        return o;
    endfunction

    // Redirect: load the new PC, squash the three younger stages, retire MEM/WB.
    function automatic pctl_out_t pctl_redirect(input pcsel_t sel);
        pctl_out_t o;
        o             = PCTL_IDLE;
        o.pc_en       = 1'b1;
        o.pc_sel      = sel;
        o.memwb_en    = 1'b1;
        o.ifid_flush  = 1'b1;
        o.idex_flush  = 1'b1;
        o.exmem_flush = 1'b1;
        return o;
    endfunction

    function automatic pctl_out_t pctl_hazard();
        pctl_out_t o;
        o            = PCTL_IDLE;
        o.exmem_en   = 1'b1;
        o.memwb_en   = 1'b1;
        o.idex_flush = 1'b1;
        return o;
    endfunction

    function automatic pctl_out_t pctl_retire();
        pctl_out_t o;
        o             = PCTL_IDLE;
        o.memwb_en    = 1'b1;
        o.exmem_flush = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Pipeline control bus: hit/hazard/resolution inputs from the datapath and the
// latch enables, flushes, PC select, halt and stall counter back to it.
interface pipeline_control_if #(
    parameter int CNT_W = 32
);
    logic                  ihit;
    logic                  dhit;
    logic                  mem_data_req;
    logic                  mem_branch;
    logic                  mem_take;
    logic                  mem_jump;
    logic                  mem_halt;
    logic                  idex_mem_read;
    logic [4:0]            idex_write_reg;
    logic [4:0]            ifid_rs;
    logic [4:0]            ifid_rt;

    logic                  pc_en;
    cpu_types_pkg::pcsel_t pc_sel;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_flush;
    logic                  halt;
    logic [CNT_W-1:0]      stall_cycles;

    modport ctrl (
        input  ihit, dhit, mem_data_req, mem_branch, mem_take, mem_jump, mem_halt,
               idex_mem_read, idex_write_reg, ifid_rs, ifid_rt,
        output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cycles
    );

    modport dp (
        output ihit, dhit, mem_data_req, mem_branch, mem_take, mem_jump, mem_halt,
               idex_mem_read, idex_write_reg, ifid_rs, ifid_rt,
        input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cycles
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard and control-flow redirect detection from the
// decode operands and the EX/MEM resolution fields.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_write_reg_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       mem_branch_i,
    input  logic       mem_take_i,
    input  logic       mem_jump_i,
    output logic       hazard_o,
    output logic       redirect_o,
    output pcsel_t     redir_sel_o
);

    // $zero never carries a dependency, so a load into r0 cannot stall.
    assign hazard_o = idex_mem_read_i && (idex_write_reg_i != 5'd0) &&
                      ((idex_write_reg_i == ifid_rs_i) || (idex_write_reg_i == ifid_rt_i));

    assign redirect_o  = (mem_branch_i && mem_take_i) || mem_jump_i;
    assign redir_sel_o = mem_jump_i ? PC_JMP : PC_BR;

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: per-cycle latch enables, flushes
// and PC source; tracks data waits, load-use bubbles, pending redirects and halt.
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    pipeline_control_if.ctrl  bus
);

    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

    pctl_state_t      state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    pcsel_t           pend_q, pend_d;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q;

    logic             hazard;
    logic             redirect;
    pcsel_t           redir_sel;
    logic             advance;
    logic             run_decide;
    pctl_out_t        out_c;

    hazard_detect u_hazard (
        .idex_mem_read_i  (bus.idex_mem_read),
        .idex_write_reg_i (bus.idex_write_reg),
        .ifid_rs_i        (bus.ifid_rs),
        .ifid_rt_i        (bus.ifid_rt),
        .mem_branch_i     (bus.mem_branch),
        .mem_take_i       (bus.mem_take),
        .mem_jump_i       (bus.mem_jump),
        .hazard_o         (hazard),
        .redirect_o       (redirect),
        .redir_sel_o      (redir_sel)
    );

    assign advance = bus.ihit && (!bus.mem_data_req || bus.dhit);

    always_comb begin
        out_c      = PCTL_IDLE;
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        pend_d     = pend_q;
        run_decide = 1'b0;

        case (state_q)
            RUN: run_decide = 1'b1;
            LU_STALL: begin
                // Halt or redirect preempts the remaining bubbles.
                if (bus.mem_halt || redirect) begin
                    run_decide = 1'b1;
                end else if (advance) begin
                    out_c    = pctl_hazard();
                    lu_cnt_d = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) state_d = RUN;
                end
            end
            DWAIT: begin
                if (bus.dhit && bus.ihit) begin
                    run_decide = 1'b1;
                end else if (bus.dhit) begin
                    // Fetch still stalled: retire the access once and drop it from EX/MEM.
                    out_c   = pctl_retire();
                    state_d = RUN;
                end
            end
            REDIR: begin
                if (bus.ihit) begin
                    out_c   = pctl_redirect(pend_q);
                    pend_d  = PC_SEQ;
                    state_d = RUN;
                end
            end
            HALT: ;
            default: state_d = RUN;
        endcase

        if (run_decide) begin
            state_d  = RUN;
            lu_cnt_d = 2'd0;
            if (bus.mem_halt) begin
                state_d = HALT;
            end else if (redirect) begin
                if (advance) begin
                    out_c = pctl_redirect(redir_sel);
                end else begin
                    pend_d  = redir_sel;
                    state_d = REDIR;
                end
            end else if (bus.mem_data_req && !bus.dhit) begin
                state_d = DWAIT;
            end else if (hazard && advance) begin
                out_c    = pctl_hazard();
                lu_cnt_d = LU_RELOAD;
                if (LU_RELOAD != 2'd0) state_d = LU_STALL;
            end else begin
                out_c = pctl_all(advance);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            lu_cnt_q <= 2'd0;
            pend_q   <= PC_SEQ;
            halt_q   <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            pend_q   <= pend_d;
            halt_q   <= (state_d == HALT);
            if ((state_q != HALT) && !out_c.pc_en && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.pc_en        = out_c.pc_en;
    assign bus.pc_sel       = out_c.pc_sel;
    assign bus.ifid_en      = out_c.ifid_en;
    assign bus.idex_en      = out_c.idex_en;
    assign bus.exmem_en     = out_c.exmem_en;
    assign bus.memwb_en     = out_c.memwb_en;
    assign bus.ifid_flush   = out_c.ifid_flush;
    assign bus.idex_flush   = out_c.idex_flush;
    assign bus.exmem_flush  = out_c.exmem_flush;
    assign bus.halt         = halt_q;
    assign bus.stall_cycles = stall_q;

endmodule
